// File: rtl/psum_sram_out_reader.sv
// -----------------------------------------------------------------------------
// psum_sram_out_reader
//
// Read-side sequencer for the output psum SRAM. A `start` pulse in IDLE walks
// GROUPS*BATCHES*CHANNELS consecutive words beginning at BASE_ADDR. Words are
// streamed to the cross-channel accumulator one per cycle, channel-major within
// each group: all batches of C0, then all batches of C1, and so on. `acc_en`
// brackets the whole pass so that the accumulator's internal index lines up
// with group boundaries.
//
// Ports
//   clock          : system clock
//   reset          : synchronous, active-high reset
//   start          : one-cycle request to begin a pass (honoured only in IDLE)
//   pause          : holds off new SRAM reads; reads in flight still complete
//   sram_rd_en     : SRAM read strobe
//   sram_addr      : SRAM read address (BASE_ADDR + word count)
//   sram_rd_data   : SRAM read data, valid the cycle after sram_rd_en
//   acc_en         : accumulator enable, high from PRIME through DRAIN
//   data_out       : streamed psum word
//   data_out_valid : data_out is valid this cycle
//   data_out_last  : final word of a group (qualified by data_out_valid)
//   busy           : high whenever the sequencer is not IDLE
//   done           : one-cycle pulse at the end of a pass
// -----------------------------------------------------------------------------
module psum_sram_out_reader #(
    parameter int BATCHES   = 4,
    parameter int CHANNELS  = 3,
    parameter int GROUPS    = 16,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     pause,
    output logic                     sram_rd_en,
    output logic [ADDR_W-1:0]        sram_addr,
    input  logic signed [20:0]       sram_rd_data,
    output logic                     acc_en,
    output logic signed [20:0]       data_out,
    output logic                     data_out_valid,
    output logic                     data_out_last,
    output logic                     busy,
    output logic                     done
);

    localparam int DATA_W = 21;
    localparam int TOTAL  = GROUPS * BATCHES * CHANNELS;
    localparam int B_W    = (BATCHES  > 1) ? $clog2(BATCHES)  : 1;
    localparam int C_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int G_W    = (GROUPS   > 1) ? $clog2(GROUPS)   : 1;

    localparam logic [B_W-1:0]    B_MAX = B_W'(BATCHES - 1);
    localparam logic [C_W-1:0]    C_MAX = C_W'(CHANNELS - 1);
    localparam logic [G_W-1:0]    G_MAX = G_W'(GROUPS - 1);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [B_W-1:0]      b_q, b_d;
    logic [C_W-1:0]      c_q, c_d;
    logic [G_W-1:0]      g_q, g_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                drain_q, drain_d;

    logic                rd_issue;
    logic                rd_group_last;

    // Read-return pipeline: _p1 tracks the read whose data is on sram_rd_data,
    // _p2 is the registered output word.
    logic                vld_p1_q;
    logic                last_p1_q;
    logic                vld_p2_q;
    logic                last_p2_q;
    logic signed [DATA_W-1:0] data_p2_q;

    // -------------------------------------------------------------------------
    // Next-state and counter logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        b_d           = b_q;
        c_d           = c_q;
        g_d           = g_q;
        addr_d        = addr_q;
        drain_d       = drain_q;
        rd_issue      = 1'b0;
        rd_group_last = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PRIME;
                    b_d     = '0;
                    c_d     = '0;
                    g_d     = '0;
                    addr_d  = BASE;
                    drain_d = 1'b0;
                end
            end

            // One cycle with acc_en high and no read, so the accumulator's
            // enable register is already set when the first word lands.
            S_PRIME: begin
                state_d = S_READ;
            end

            S_READ: begin
                if (!pause) begin
                    rd_issue      = 1'b1;
                    rd_group_last = (b_q == B_MAX) && (c_q == C_MAX);
                    addr_d        = addr_q + ADDR_W'(1);
                    // b wraps into c, c wraps into g; the last word of the
                    // last group ends the read phase.
                    if (b_q == B_MAX) begin
                        b_d = '0;
                        if (c_q == C_MAX) begin
                            c_d = '0;
                            if (g_q == G_MAX) begin
                                g_d     = '0;
                                state_d = S_DRAIN;
                            end else begin
                                g_d = g_q + G_W'(1);
                            end
                        end else begin
                            c_d = c_q + C_W'(1);
                        end
                    end else begin
                        b_d = b_q + B_W'(1);
                    end
                end
            end

            // Two cycles cover the SRAM latency plus the output register.
            S_DRAIN: begin
                if (drain_q) begin
                    drain_d = 1'b0;
                    state_d = S_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, counters and read-return pipeline
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            b_q       <= '0;
            c_q       <= '0;
            g_q       <= '0;
            addr_q    <= '0;
            drain_q   <= 1'b0;
            vld_p1_q  <= 1'b0;
            last_p1_q <= 1'b0;
            vld_p2_q  <= 1'b0;
            last_p2_q <= 1'b0;
            data_p2_q <= '0;
        end else begin
            state_q   <= state_d;
            b_q       <= b_d;
            c_q       <= c_d;
            g_q       <= g_d;
            addr_q    <= addr_d;
            drain_q   <= drain_d;
            // p0 -> p1: read issued, data arrives from the SRAM
            vld_p1_q  <= rd_issue;
            last_p1_q <= rd_group_last;
            // p1 -> p2: capture returned word
            vld_p2_q  <= vld_p1_q;
            last_p2_q <= last_p1_q;
            if (vld_p1_q) begin
                data_p2_q <= sram_rd_data;
            end
        end
    end

    assign sram_rd_en     = rd_issue;
    assign sram_addr      = addr_q;
    assign acc_en         = (state_q == S_PRIME) || (state_q == S_READ) ||
                            (state_q == S_DRAIN);
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign data_out       = data_p2_q;
    assign data_out_valid = vld_p2_q;
    assign data_out_last  = last_p2_q;

`ifndef SYNTHESIS
    // The region must fit in the address space without wrapping.
    always @(posedge clock) begin
        if (!reset) begin
            assert (BASE_ADDR + TOTAL <= (1 << ADDR_W))
            else $error("psum_sram_out_reader: region exceeds address space");
        end
    end
`endif

endmodule

// File: tb/tb_psum_sram_out_reader.sv
module tb_psum_sram_out_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        st;
    logic [2:0]        pz;
    logic [2:0]        rs;
    logic              rd   [3];
    logic [9:0]        ad   [3];
    logic signed [20:0] rdat [3];
    logic              acc  [3];
    logic signed [20:0] dout [3];
    logic              vld  [3];
    logic              lst  [3];
    logic              bsy  [3];
    logic              dn   [3];

    // u0: default configuration, u1: BASE_ADDR 40 with signed ramp data,
    // u2: a single-word pass.
    psum_sram_out_reader u0 (
        .clock(clk), .reset(rs[0]), .start(st[0]), .pause(pz[0]),
        .sram_rd_en(rd[0]), .sram_addr(ad[0]), .sram_rd_data(rdat[0]),
        .acc_en(acc[0]), .data_out(dout[0]), .data_out_valid(vld[0]),
        .data_out_last(lst[0]), .busy(bsy[0]), .done(dn[0]));

    psum_sram_out_reader #(.BASE_ADDR(40)) u1 (
        .clock(clk), .reset(rs[1]), .start(st[1]), .pause(pz[1]),
        .sram_rd_en(rd[1]), .sram_addr(ad[1]), .sram_rd_data(rdat[1]),
        .acc_en(acc[1]), .data_out(dout[1]), .data_out_valid(vld[1]),
        .data_out_last(lst[1]), .busy(bsy[1]), .done(dn[1]));

    psum_sram_out_reader #(.GROUPS(1), .BATCHES(1), .CHANNELS(1)) u2 (
        .clock(clk), .reset(rs[2]), .start(st[2]), .pause(pz[2]),
        .sram_rd_en(rd[2]), .sram_addr(ad[2]), .sram_rd_data(rdat[2]),
        .acc_en(acc[2]), .data_out(dout[2]), .data_out_valid(vld[2]),
        .data_out_last(lst[2]), .busy(bsy[2]), .done(dn[2]));

    // Signed ramp over 192 words: word 0 -> -1000, word 191 -> +1000.
    function automatic int ramp(input int w);
        return -1000 + (w * 2000) / 191;
    endfunction

    function automatic int val(input int d, input int a);
        if (d == 1) return ramp(a - 40);
        return a + 100;
    endfunction

    // SRAM models: one cycle read latency.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rd[d]) rdat[d] <= 21'(val(d, int'(ad[d])));
        end
    end

    int BASE [3] = '{0, 40, 0};
    int N    [3] = '{192, 192, 1};
    int BC   [3] = '{12, 12, 1};

    int rd_cnt [3];
    int out_cnt[3];
    int last_rd[3];
    int first_v[3];
    int last_v [3];
    int n_last [3];
    bit rd_h1  [3];
    bit rd_h2  [3];
    bit acc_h1 [3];
    int accv   [4];
    int lit_w0, lit_w191, lit_s0, lit_s1;
    int n_cmp, n_bad, cyc;

    task automatic cmp(input int d, input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL dut%0d %s: got %0d, want %0d (cycle %0d)", d, nm, act, exp, cyc);
        end
    endtask

    task automatic clear(input int d);
        rd_cnt[d]  = 0;
        out_cnt[d] = 0;
        first_v[d] = -1;
        last_v[d]  = -1;
        n_last[d]  = 0;
        rd_h1[d]   = 1'b0;
        rd_h2[d]   = 1'b0;
        acc_h1[d]  = 1'b0;
        if (d == 1) for (int b = 0; b < 4; b++) accv[b] = 0;
    endtask

    // Per-cycle comparison of one DUT against the stream model.
    task automatic check_dut(input int d);
        int a, q, j, g, e;
        a = int'(ad[d]);
        q = int'(dout[d]);
        cmp(d, "valid_vs_read", int'(vld[d]), int'(rd_h2[d]));
        if (rd[d]) begin
            cmp(d, "rd_addr", a, (BASE[d] + rd_cnt[d]) % 1024);
            cmp(d, "rd_in_pause", int'(pz[d]), 0);
            if (rd_cnt[d] == 0)
                cmp(d, "prime_before_read", (acc_h1[d] && !rd_h1[d]) ? 1 : 0, 1);
            rd_cnt[d]++;
            last_rd[d] = cyc;
            if (rd_cnt[d] > N[d]) cmp(d, "rd_overrun", rd_cnt[d], N[d]);
        end
        if (vld[d]) begin
            cmp(d, "valid_acc_en", int'(acc[d]), 1);
            cmp(d, "data", q, val(d, BASE[d] + out_cnt[d]));
            cmp(d, "last", int'(lst[d]), (out_cnt[d] % BC[d] == BC[d] - 1) ? 1 : 0);
            if (d == 0 && out_cnt[d] == 0)   lit_w0   = q;
            if (d == 0 && out_cnt[d] == 191) lit_w191 = q;
            if (lst[d]) n_last[d]++;
            if (d == 1) begin
                j = out_cnt[d] % 12;
                accv[j % 4] += q;
                if (j == 11) begin
                    g = out_cnt[d] / 12;
                    for (int b = 0; b < 4; b++) begin
                        e = ramp(g*12 + b) + ramp(g*12 + 4 + b) + ramp(g*12 + 8 + b);
                        cmp(d, "acc_sum", accv[b], e);
                        if (g == 0 && b == 0)  lit_s0 = accv[b];
                        if (g == 15 && b == 3) lit_s1 = accv[b];
                        accv[b] = 0;
                    end
                end
            end
            if (first_v[d] < 0) first_v[d] = cyc;
            last_v[d] = cyc;
            out_cnt[d]++;
        end else begin
            cmp(d, "last_without_valid", int'(lst[d]), 0);
        end
        if (dn[d]) begin
            cmp(d, "done_words", out_cnt[d], N[d]);
            cmp(d, "done_latency", cyc - last_rd[d], 3);
            cmp(d, "done_acc_en", int'(acc[d]), 0);
            cmp(d, "done_busy", int'(bsy[d]), 1);
        end
        rd_h2[d]  = rd_h1[d];
        rd_h1[d]  = rd[d];
        acc_h1[d] = acc[d];
    endtask

    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < 3; d++) check_dut(d);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass(input int d);
        clear(d);
        st[d] = 1'b1;
        tick();
        st[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int budget);
        int k;
        k = 0;
        while (!dn[d] && k < budget) begin
            tick();
            k++;
        end
        if (!dn[d]) cmp(d, "done_timeout", 0, 1);
    endtask

    task automatic zero_chk(input int d);
        cmp(d, "rst_rd_en", int'(rd[d]), 0);
        cmp(d, "rst_addr", int'(ad[d]), 0);
        cmp(d, "rst_data", int'(dout[d]), 0);
        cmp(d, "rst_valid", int'(vld[d]), 0);
        cmp(d, "rst_last", int'(lst[d]), 0);
        cmp(d, "rst_acc_en", int'(acc[d]), 0);
        cmp(d, "rst_busy", int'(bsy[d]), 0);
        cmp(d, "rst_done", int'(dn[d]), 0);
    endtask

    initial begin
        int k;
        st = '0; pz = '0; rs = 3'b111;
        n_cmp = 0; n_bad = 0; cyc = 0;
        lit_w0 = 12345; lit_w191 = 12345; lit_s0 = 12345; lit_s1 = 12345;
        for (int d = 0; d < 3; d++) clear(d);
        tick();
        tick();
        for (int d = 0; d < 3; d++) zero_chk(d);
        rs = '0;
        tick();

        // Full pass, default configuration
        start_pass(0);
        wait_done(0, 400);
        tick();
        cmp(0, "t1_words", out_cnt[0], 192);
        cmp(0, "t1_lasts", n_last[0], 16);
        cmp(0, "t1_gap", last_v[0] - first_v[0] + 1 - 192, 0);
        cmp(0, "t1_word0", lit_w0, 100);
        cmp(0, "t1_word191", lit_w191, 291);

        // Pause for 5 cycles after the 7th read
        start_pass(0);
        k = 0;
        while (rd_cnt[0] < 7 && k < 100) begin tick(); k++; end
        cmp(0, "t2_reach7", rd_cnt[0], 7);
        pz[0] = 1'b1;
        repeat (5) tick();
        pz[0] = 1'b0;
        wait_done(0, 400);
        tick();
        cmp(0, "t2_words", out_cnt[0], 192);
        cmp(0, "t2_gap", last_v[0] - first_v[0] + 1 - 192, 5);

        // start mid-pass and in DONE ignored; start in IDLE accepted
        start_pass(0);
        repeat (20) tick();
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        cmp(0, "t3_busy_mid", int'(bsy[0]), 1);
        wait_done(0, 400);
        st[0] = 1'b1;
        tick();
        cmp(0, "t3_idle_after_done", int'(bsy[0]), 0);
        clear(0);
        tick();
        st[0] = 1'b0;
        cmp(0, "t3_second_pass_busy", int'(bsy[0]), 1);
        wait_done(0, 400);
        tick();
        cmp(0, "t3_second_words", out_cnt[0], 192);

        // Reset while on word 50
        start_pass(0);
        k = 0;
        while (out_cnt[0] < 50 && k < 200) begin tick(); k++; end
        rs[0] = 1'b1;
        tick();
        rs[0] = 1'b0;
        zero_chk(0);
        clear(0);
        repeat (6) tick();
        cmp(0, "t4_no_valid_after_reset", out_cnt[0], 0);
        start_pass(0);
        wait_done(0, 400);
        tick();
        cmp(0, "t4_replay_words", out_cnt[0], 192);

        // BASE_ADDR 40, signed ramp, accumulator sums
        start_pass(1);
        wait_done(1, 400);
        tick();
        cmp(1, "t5_words", out_cnt[1], 192);
        cmp(1, "t5_lasts", n_last[1], 16);
        cmp(1, "t5_sum_g0_b0", lit_s0, -2876);
        cmp(1, "t5_sum_g15_b3", lit_s1, 2874);

        // Single-word pass
        start_pass(2);
        wait_done(2, 50);
        tick();
        cmp(2, "t6_words", out_cnt[2], 1);
        cmp(2, "t6_lasts", n_last[2], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/psum_sram_out_reader.md
Name: psum_sram_out_reader

Overview:
Read-side sequencer for the output psum SRAM. On `start` it walks a contiguous region of GROUPS*BATCHES*CHANNELS words and streams them to the downstream cross-channel accumulator. Each group is emitted in channel-major order (all batches of C0, then all batches of C1, ...), one word per cycle. It also drives the accumulator's enable window, so the accumulator's internal index is aligned to group boundaries.

Parameters:
BATCHES, 4, batches per channel slice (inner loop).
CHANNELS, 3, channel slices per group (outer loop within a group).
GROUPS, 16, groups read per `start`.
ADDR_W, 10, SRAM address width.
BASE_ADDR, 0, address of word 0 of the region.

Ports:
clock  in  1  system clock.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle request to begin a read pass; ignored unless in IDLE.
pause  in  1  while high, no new SRAM reads are issued; reads already in flight still complete.
sram_rd_en  out  1  SRAM read strobe.
sram_addr  out  ADDR_W  SRAM read address.
sram_rd_data  in  21 signed  SRAM read data; valid the cycle after `sram_rd_en`.
acc_en  out  1  enable to the downstream accumulator; high from PRIME through DRAIN.
data_out  out  21 signed  streamed psum word.
data_out_valid  out  1  `data_out` is valid this cycle.
data_out_last  out  1  marks the final word of a group (`data_out_valid` is also high).
busy  out  1  high whenever the state is not IDLE.
done  out  1  one-cycle pulse at the end of a pass.

Behaviour:
- Reset: state IDLE; all counters 0. Every output is 0 (`sram_addr`, `data_out`, all flags).
- Counters:
  - b: 0..BATCHES-1.
  - c: 0..CHANNELS-1.
  - g: 0..GROUPS-1.
  - Word count w = g*BATCHES*CHANNELS + c*BATCHES + b.
  - `sram_addr` = BASE_ADDR + w, held as a registered incrementer.
  - Order: b wraps into c, c wraps into g.
- States:
  - IDLE -> PRIME on `start`.
  - PRIME: lasts exactly 1 cycle. `acc_en` = 1 and no read is issued, so the accumulator's enable register is set before the first data arrives. Next state is READ.
  - READ: when `pause` = 0, assert `sram_rd_en` at the current address and advance the counters. When `pause` = 1, `sram_rd_en` = 0 and the counters hold. After issuing the read of the final word (w = GROUPS*BATCHES*CHANNELS-1), go to DRAIN.
  - DRAIN: wait 2 cycles for the in-flight reads, then go to DONE. `pause` is ignored.
  - DONE: lasts 1 cycle. `done` = 1 and `acc_en` = 0. Next state is IDLE.
- Datapath:
  - `rd_en_d1` = `sram_rd_en` delayed one cycle.
  - `data_out` is registered from `sram_rd_data` when `rd_en_d1` = 1; otherwise it holds its value.
  - `data_out_valid` = `rd_en_d1` delayed one cycle, so latency from `sram_rd_en` to `data_out_valid` is 2 cycles.
  - `data_out_last` is delayed by the same pipeline. It is set when the issued read had b = BATCHES-1 and c = CHANNELS-1.
- No backpressure from downstream. `pause` only gaps the stream. Bubbles are allowed mid-group; the group index is unaffected by them.
- `start` while `busy` = 1: ignored, with no effect on counters.
- `start` on the same cycle as `done`: ignored. A new pass needs `start` while in IDLE.
- GROUPS = 1 is legal. A read pass produces exactly GROUPS*BATCHES*CHANNELS valid words.
- Reset mid-pass: on the next cycle the block is in IDLE with all outputs 0. In-flight pipeline data is discarded and no `data_out_valid` appears afterwards.
- Address arithmetic wraps modulo 2^ADDR_W. Configurations where BASE_ADDR + GROUPS*BATCHES*CHANNELS > 2^ADDR_W are unsupported and are flagged by a simulation-only assertion.

Test Plan:
1. Defaults, SRAM model holding addr+100. Pulse `start`.
   - Expect `acc_en` high 1 cycle before the first `sram_rd_en`.
   - Expect 192 valid words with values 100..291 in order.
   - Expect `data_out_valid` 2 cycles after each `sram_rd_en`.
   - Expect `data_out_last` on words 11, 23, ..., 191.
   - Expect `done` pulse 3 cycles after the last read.
2. `pause` high for 5 cycles after the 7th read.
   - Expect no `sram_rd_en` during the pause and a gap of exactly 5 cycles in `data_out_valid`.
   - Expect the sequence unchanged, with no duplicates or skipped words.
3. `start` re-pulsed mid-pass and again in the DONE cycle.
   - Expect both ignored and the total word count still 192.
   - A `start` issued 1 cycle later (in IDLE) runs a second full pass.
4. `reset` asserted while on word 50.
   - Next cycle: all outputs 0, `busy` = 0, no further `data_out_valid`.
   - A new `start` replays from addr 0.
5. Chain with the downstream accumulator, BASE_ADDR = 40, data = signed ramp spanning -1000..+1000.
   - Accumulator outputs equal the per-batch sums over the 3 channels for every group.
   - `data_out_valid` never appears while `acc_en` = 0.
6. GROUPS = 1 and BATCHES = 1, CHANNELS = 1.
   - Expect exactly 1 valid word with `data_out_last` = 1.
   - Expect `done` 3 cycles after its read.
